muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide controller for the RV32M extension, sitting beside the execute stage's ALU. It accepts one M-type operation from the execute stage and runs a 32-iteration shift-add multiply or restoring divide. While it runs, it holds the pipeline with a stall signal. It returns a single 32-bit result with a one-cycle done pulse, which the execute stage muxes onto its ALU result path.

## Interface
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request to begin an operation; sampled only in IDLE.
- op_i  input  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcA_i  input  DATA_WIDTH  rs1 operand (multiplicand / dividend).
- srcB_i  input  DATA_WIDTH  rs2 operand (multiplier / divisor).
- flush_i  input  1  abort the in-flight operation (branch mispredict / jump).
- busy_o  output  1  stall request to the hazard unit.
- done_o  output  1  one-cycle pulse; result_o valid.
- result_o  output  DATA_WIDTH  registered result; holds the last value until the next done.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - If start_i=1 and flush_i=0: latch op_i, srcA_i and srcB_i.
  - Signed ops (MUL/MULH/MULHSU rs1, MULH rs2, DIV/REM both operands) are converted to magnitudes, and the result sign is recorded.
  - Special cases go directly to DONE:
    - Divisor zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
    - DIV with 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
  - All other operations go to CALC, with the 6-bit iteration counter cleared.
- **CALC:** exactly 32 iterations, counter 0..31.
  - Multiply: 64-bit accumulator; add the multiplicand when the current multiplier LSB is 1, then shift right one.
  - Divide: shift remainder:quotient left one, trial-subtract the divisor, set the quotient bit when the subtraction does not underflow.
  - When counter = 31, advance to FIX.
- **FIX:** apply the sign correction.
  - Two's-complement the 64-bit product if its sign is negative.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder takes the sign of the dividend.
  - Select the output: product[31:0] for MUL, product[63:32] for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register the selection into result_o, then advance to DONE.
- **DONE:** done_o=1 for one cycle, then go to IDLE.
  - start_i is ignored in DONE; a back-to-back op is accepted in the following IDLE cycle.
- **busy_o (combinational):** (state==IDLE & start_i & !flush_i) | state==CALC | state==FIX.
  - busy_o is low in DONE so the pipeline advances and captures result_o that same cycle.
- **Ignored inputs:** start_i is ignored outside IDLE; operand changes after latch have no effect.
- **flush_i:**
  - In any state, return to IDLE on the next edge; done_o is not asserted and result_o is unchanged.
  - flush_i wins over start_i in the same cycle.
- **rst:** state IDLE, counter 0, result_o 0, busy_o 0, done_o 0, latched operands 0. rst mid-operation aborts like flush.

## Timing
- Start accepted at edge k (start_i=1 in the IDLE cycle before edge k).
- Normal op: CALC occupies cycles k..k+31, FIX cycle k+32, DONE cycle k+33.
  - done_o is high during cycle k+33; latency is 34 cycles from acceptance.
- Special case: DONE in cycle k, so done_o is high in the cycle immediately after acceptance.
- busy_o rises combinationally in the start cycle, with no bubble before the stall.
- result_o changes only at the FIX→DONE edge or the IDLE→DONE edge.
- done_o and busy_o are never high together.

## Test plan
- **Reset:** assert rst 2 cycles → busy_o=0, done_o=0, result_o=0; then MUL 7 × 0xFFFFFFFD → result 0xFFFFFFEB, done_o exactly 34 cycles after acceptance, busy_o high for the 33 preceding cycles.
- **MULH/MULHU/MULHSU:**
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed division:**
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- **Special cases:**
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - Each gives done_o one cycle after acceptance.
- **Flush mid-operation:**
  - flush_i in CALC iteration 10 → IDLE next edge, busy_o=0, no done_o, result_o holds its prior value.
  - A new start in the next cycle completes normally.
  - flush_i and start_i together in IDLE → no acceptance.
- **Back-to-back ops with a noisy start:** hold start_i high continuously with changing operands → each op uses the operands from its IDLE acceptance cycle, one op per 35 cycles; rst asserted mid-CALC → outputs return to reset values on the next edge.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit with pipeline stall and done pulse
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] srcA_i,
  input  logic [DATA_WIDTH-1:0] srcB_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [2:0] op_q;
  logic [31:0] a_q, b_q;
  logic neg_q, neg_r;
  logic [63:0] acc;
  logic a_neg, b_neg, div_zero, div_ovf;
  logic [31:0] a_mag, b_mag, special_res;
  logic [32:0] mul_sum;
  logic [33:0] trial;
  logic [63:0] mul_next, div_next, prod;
  logic [31:0] quo, rem, fix_res;
  // operand sign handling and special-case detection for the op offered in IDLE
  always_comb begin
    a_neg = srcA_i[31] & (op_i[2] ? !op_i[0] : op_i[1:0] != 2'b11);
    b_neg = srcB_i[31] & (op_i == 3'b001 || op_i == 3'b100 || op_i == 3'b110);
    a_mag = a_neg ? -srcA_i : srcA_i;
    b_mag = b_neg ? -srcB_i : srcB_i;
    div_zero = op_i[2] && srcB_i == 32'h0;
    div_ovf = op_i[2] && !op_i[0] && srcA_i == 32'h8000_0000 && srcB_i == 32'hFFFF_FFFF;
    special_res = div_zero ? (op_i[1] ? srcA_i : 32'hFFFF_FFFF) : (op_i[1] ? 32'h0 : 32'h8000_0000);
  end
  // one shift-add multiply step or one restoring-divide step on the shared accumulator
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_q} : 33'h0);
    mul_next = {mul_sum, acc[31:1]};
    trial = {1'b0, acc[63:31]} - {2'b00, b_q};
    div_next = trial[33] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
  end
  // sign correction and result selection applied in FIX
  always_comb begin
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[31:0] : acc[31:0];
    rem = neg_r ? -acc[63:32] : acc[63:32];
    fix_res = op_q == 3'b000 ? prod[31:0] : !op_q[2] ? prod[63:32] : op_q[1] ? rem : quo;
  end
  assign busy_o = (state == IDLE && start_i && !flush_i) || state == CALC || state == FIX;
  // sequencer: accept, iterate 32 times, fix up, pulse done; flush aborts from any state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 6'd0;
      op_q <= 3'd0;
      a_q <= 32'h0;
      b_q <= 32'h0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      acc <= 64'h0;
      result_o <= '0;
      done_o <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            op_q <= op_i;
            a_q <= a_mag;
            b_q <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            acc <= {32'h0, op_i[2] ? a_mag : b_mag};
            cnt <= 6'd0;
            if (div_zero || div_ovf) begin
              result_o <= special_res;
              done_o <= 1'b1;
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= op_q[2] ? div_next : mul_next;
          cnt <= cnt + 6'd1;
          state <= cnt == 6'd31 ? FIX : CALC;
        end
        FIX: begin
          result_o <= fix_res;
          done_o <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed scoreboard bench for the iterative multiply/divide unit
module tb_muldiv_sequencer;
  logic clk, rst, start_i, flush_i, busy_o, done_o;
  logic [2:0] op_i;
  logic [31:0] srcA_i, srcB_i, result_o;
  logic [31:0] q[$];
  int n_assert = 0;
  int n_fail = 0;
  int overlap = 0;
  int c;
  bit bl, dl;
  logic [31:0] prior;

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .srcA_i(srcA_i),
    .srcB_i(srcB_i), .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done_o && busy_o) overlap++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    int si, sj;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    si = a;
    sj = b;
    up = ua * ub;
    if (op == 3'd0) return up[31:0];
    if (op == 3'd3) return up[63:32];
    if (op == 3'd1) begin sp = sa * sb; return sp[63:32]; end
    if (op == 3'd2) begin sp = sa * $signed(ub); return sp[63:32]; end
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op == 3'd4) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
      si = si / sj;
      return si;
    end
    if (op == 3'd6) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
      si = si % sj;
      return si;
    end
    if (op == 3'd5) return a / b;
    return a % b;
  endfunction

  task automatic wait_done(input bit noisy, output int cyc, output bit busy_low);
    cyc = 0;
    busy_low = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (noisy) begin
        srcA_i = $urandom;
        srcB_i = $urandom;
        op_i = 3'($urandom_range(0, 7));
      end else start_i = 1'b0;
      if (!done_o && !busy_o) busy_low = 1;
    end while (!done_o && cyc < 100);
  endtask

  task automatic check_done(input string tag, input int lat, input int cyc, input bit busy_low);
    logic [31:0] exp;
    exp = q.size() != 0 ? q.pop_front() : 32'hx;
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_busy_held"}, {31'h0, busy_low}, 32'h0);
    chk({tag, "_done"}, {31'h0, done_o}, 32'h1);
    chk({tag, "_result"}, result_o, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit special);
    int cyc;
    bit busy_low;
    @(negedge clk);
    op_i = op;
    srcA_i = a;
    srcB_i = b;
    start_i = 1'b1;
    q.push_back(exp);
    #1 chk({tag, "_busy_comb"}, {31'h0, busy_o}, 32'h1);
    wait_done(0, cyc, busy_low);
    check_done(tag, special ? 1 : 34, cyc, busy_low);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'h0, done_o}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i = 3'd0;
    srcA_i = 32'h0;
    srcB_i = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_result", result_o, 32'h0);
    rst = 1'b0;
    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 0);
    run_op("divu_zero", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_zero", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("mul_model", 3'd0, 32'h1234_5678, 32'h0BAD_F00D, model(3'd0, 32'h1234_5678, 32'h0BAD_F00D), 0);
    // flush during CALC iteration 10
    prior = result_o;
    @(negedge clk);
    op_i = 3'd1;
    srcA_i = 32'hDEAD_BEEF;
    srcB_i = 32'h1357_9BDF;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy", {31'h0, busy_o}, 32'h0);
    chk("flush_done", {31'h0, done_o}, 32'h0);
    chk("flush_result", result_o, prior);
    run_op("after_flush", 3'd5, 32'd1000, 32'd33, 32'd30, 0);
    // flush and start together in IDLE
    @(negedge clk);
    op_i = 3'd0;
    srcA_i = 32'd3;
    srcB_i = 32'd3;
    start_i = 1'b1;
    flush_i = 1'b1;
    #1 chk("flush_start_busy", {31'h0, busy_o}, 32'h0);
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    #1 chk("flush_start_idle", {31'h0, busy_o}, 32'h0);
    dl = 0;
    repeat (36) begin
      @(negedge clk);
      if (done_o) dl = 1;
    end
    chk("flush_start_no_done", {31'h0, dl}, 32'h0);
    chk("flush_start_result", result_o, 32'd30);
    // start held high with operands changing every cycle after acceptance
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      start_i = 1'b1;
      op_i = n == 0 ? 3'd1 : n == 1 ? 3'd4 : 3'd7;
      srcA_i = n == 0 ? 32'h1234_5678 : n == 1 ? 32'h8765_4321 : 32'hDEAD_BEEF;
      srcB_i = n == 0 ? 32'h9ABC_DEF0 : n == 1 ? 32'h0000_1234 : 32'h0000_0777;
      q.push_back(model(op_i, srcA_i, srcB_i));
      wait_done(1, c, bl);
      check_done("noisy", 34, c, bl);
    end
    // reset in the middle of CALC
    @(negedge clk);
    op_i = 3'd0;
    srcA_i = 32'd9;
    srcB_i = 32'd9;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'h0, busy_o}, 32'h0);
    chk("midrst_done", {31'h0, done_o}, 32'h0);
    chk("midrst_result", result_o, 32'h0);
    rst = 1'b0;
    run_op("after_rst", 3'd3, 32'h8000_0000, 32'd4, 32'd2, 0);
    chk("no_overlap", overlap, 32'd0);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
